// File: rtl/tx_buff_ctrl.sv
// tx_buff_ctrl: control stage for a double-buffered transmit datapath.
// Host words arrive over valid/ready and are loaded alternately into buffer 0
// and buffer 1. Each buffer is then serialized MSB-first with CLK_DIV clk
// cycles per bit. fill_sel and passTXbuff advance independently, which gives
// a 2-deep ping-pong that keeps the words in FIFO order.
module tx_buff_ctrl #(
  parameter int WIDTH   = 32,
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tx_en,
  input  logic word_valid,
  output logic word_ready,
  output logic StartTX,
  output logic LoadTXBuff0,
  output logic LoadTXBuff1,
  output logic ShiftTXBuff0,
  output logic ShiftTXBuff1,
  output logic passTXbuff,
  output logic tx_active,
  output logic word_done
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] BIT_ONE  = CW'(1);
  localparam logic [CW-1:0] BIT_ZERO = CW'(0);
  localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic          r_start;
  logic          r_full0;
  logic          r_full1;
  logic          r_fill_sel;
  logic          r_pass;
  logic [0:0]    r_state;
  logic [CW-1:0] r_bit_cnt;
  logic [7:0]    r_div_cnt;

  logic          w_fill_full;
  logic          w_ready;
  logic          w_accept;
  logic          w_load0;
  logic          w_load1;
  logic          w_drain_full;
  logic          w_other_full;
  logic          w_shift;
  logic          w_release;
  logic [0:0]    w_state_nxt;
  logic [CW-1:0] w_bit_nxt;
  logic [7:0]    w_div_nxt;
  logic          w_full0_nxt;
  logic          w_full1_nxt;

  // Fill side: a buffer can take a word only while it is empty and the
  // datapath is enabled; the load strobe fires in the same cycle as the
  // accept because the host drives TXIn only during that cycle.
  always_comb begin
    w_fill_full = r_fill_sel ? r_full1 : r_full0;
    w_ready     = r_start & ~w_fill_full;
    w_accept    = word_valid & w_ready;
    w_load0     = w_accept & ~r_fill_sel;
    w_load1     = w_accept & r_fill_sel;
  end

  // Drain side: bit timing, shift strobes and word release. When StartTX is
  // low, every counter and the state hold, so the bit in flight resumes
  // where it stopped.
  always_comb begin
    w_state_nxt  = r_state;
    w_bit_nxt    = r_bit_cnt;
    w_div_nxt    = r_div_cnt;
    w_shift      = 1'b0;
    w_release    = 1'b0;
    w_drain_full = r_pass ? r_full1 : r_full0;
    w_other_full = r_pass ? r_full0 : r_full1;
    if (r_start) begin
      case (r_state)
        ST_IDLE: begin
          if (w_drain_full) begin
            w_state_nxt = ST_SHIFT;
            w_bit_nxt   = BIT_ZERO;
            w_div_nxt   = 8'd0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (r_div_cnt == DIV_LAST) begin
            w_div_nxt = 8'd0;
            if (r_bit_cnt != BIT_LAST) begin
              w_shift   = 1'b1;
              w_bit_nxt = r_bit_cnt + BIT_ONE;
            end else begin
              // The last bit ends without a shift; the other buffer, if it
              // is full, starts immediately so there is no gap on TXOut.
              w_release   = 1'b1;
              w_bit_nxt   = BIT_ZERO;
              w_state_nxt = w_other_full ? ST_SHIFT : ST_IDLE;
            end
          end else begin
            w_div_nxt = r_div_cnt + 8'd1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_bit_nxt   = BIT_ZERO;
          w_div_nxt   = 8'd0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Full flags: set on load, cleared on release. A release and a load can
  // both happen in one cycle only on different buffers, because word_ready
  // is computed from the flag value before the edge.
  always_comb begin
    w_full0_nxt = (r_full0 & ~(w_release & ~r_pass)) | w_load0;
    w_full1_nxt = (r_full1 & ~(w_release & r_pass)) | w_load1;
  end

  // State registers; reset abandons any word in flight by clearing the flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start    <= 1'b0;
      r_full0    <= 1'b0;
      r_full1    <= 1'b0;
      r_fill_sel <= 1'b0;
      r_pass     <= 1'b0;
      r_state    <= ST_IDLE;
      r_bit_cnt  <= BIT_ZERO;
      r_div_cnt  <= 8'd0;
    end else begin
      r_start    <= tx_en;
      r_full0    <= w_full0_nxt;
      r_full1    <= w_full1_nxt;
      r_fill_sel <= r_fill_sel ^ w_accept;
      r_pass     <= r_pass ^ w_release;
      r_state    <= w_state_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_div_cnt  <= w_div_nxt;
    end
  end

  assign word_ready   = w_ready;
  assign StartTX      = r_start;
  assign LoadTXBuff0  = w_load0;
  assign LoadTXBuff1  = w_load1;
  assign ShiftTXBuff0 = w_shift & ~r_pass;
  assign ShiftTXBuff1 = w_shift & r_pass;
  assign passTXbuff   = r_pass;
  assign tx_active    = (r_state == ST_SHIFT);
  assign word_done    = w_release;

endmodule
